counter_receiver: RTL

Receiving end of the counter stream driven by the send counter. Captures the NUM_SLICE×NUM_COUNTER counter words it emits, stores them in a slice/counter-indexed buffer and accumulates a saturating sum per slice. Signals completion and exposes the buffer and per-slice sums through registered read ports to the downstream sketch-decoding logic.

---
 rtl/counter_recv_pkg.sv | 22 ++
 rtl/sat_acc32.sv | 17 +
 rtl/counter_receiver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/counter_recv_pkg.sv
// Shared types and constants for the counter stream receiver.
package counter_recv_pkg;

  localparam int unsigned IDX_W   = 8;
  localparam logic [31:0] SUM_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } recv_state_t;

  function automatic int unsigned total_words(input int unsigned num_slice,
                                              input int unsigned num_counter);
    return num_slice * num_counter;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_acc32.sv
// 32-bit saturating adder: a + b clamped to SUM_MAX.
module sat_acc32
  import counter_recv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [32:0] sum_wide;

  always_comb begin
    sum_wide = {1'b0, a} + {1'b0, b};
    y        = sum_wide[32] ? SUM_MAX : sum_wide[31:0];
  end

endmodule

// File: rtl/counter_receiver.sv
// Captures NUM_SLICE x NUM_COUNTER counter words into a buffer with per-slice saturating sums.
// Optional range check on captured words is enabled by defining RECV_RANGE_CHECK_EN.
module counter_receiver
  import counter_recv_pkg::*;
#(
  parameter int unsigned NUM_COUNTER = 10,
  parameter int unsigned NUM_SLICE   = 2,
  parameter int unsigned VAL_MAX     = 100
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Counter,
  input  logic        Clear,
  input  logic [7:0]  Rd_Addr,
  output logic [31:0] Rd_Data,
  input  logic [7:0]  Slice_Sel,
  output logic [31:0] Slice_Sum,
  output logic [7:0]  Recv_Cnt,
  output logic        Done,
  output logic        Overrun,
  output logic        Range_Err
);

  localparam int unsigned TOTAL  = total_words(NUM_SLICE, NUM_COUNTER);
  localparam int unsigned BUF_AW = idx_bits(TOTAL);
  localparam int unsigned SL_AW  = idx_bits(NUM_SLICE);

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(NUM_COUNTER - 1);
  localparam logic [IDX_W-1:0] TOTAL_W   = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] NSLICE_W  = IDX_W'(NUM_SLICE);

  recv_state_t       state_q, state_d;
  logic              restart;
  logic              capture;
  logic              overrun_hit;
  logic [IDX_W-1:0]  recv_cnt_q;
  logic [IDX_W-1:0]  slice_idx_q;
  logic [IDX_W-1:0]  cnt_idx_q;
  logic [31:0]       buf_q [TOTAL];
  logic [31:0]       sum_q [NUM_SLICE];
  logic [31:0]       sum_cur;
  logic [31:0]       sum_new;
  logic [31:0]       rd_data_q;
  logic [31:0]       slice_sum_q;
  logic              overrun_q;

  assign restart = !Reset_n || Clear;

  always_ff @(posedge Clk) begin
    if (restart) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    overrun_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Counter != '0) begin
          capture = 1'b1;
          state_d = (TOTAL == 1) ? DONE : RECV;
        end
      end
      RECV: begin
        if (Counter != '0) begin
          capture = 1'b1;
          if (recv_cnt_q == LAST_WORD) state_d = DONE;
        end
      end
      DONE:    overrun_hit = (Counter != '0);
      default: state_d = IDLE;
    endcase
  end

  // One shared adder serves whichever slice is currently being filled.
  assign sum_cur = sum_q[slice_idx_q[SL_AW-1:0]];

  sat_acc32 u_sat_acc (
    .a (sum_cur),
    .b (Counter),
    .y (sum_new)
  );

  always_ff @(posedge Clk) begin
    if (restart) begin
      buf_q       <= '{default: '0};
      sum_q       <= '{default: '0};
      recv_cnt_q  <= '0;
      slice_idx_q <= '0;
      cnt_idx_q   <= '0;
      overrun_q   <= 1'b0;
      rd_data_q   <= '0;
      slice_sum_q <= '0;
    end else begin
      if (capture) begin
        buf_q[recv_cnt_q[BUF_AW-1:0]] <= Counter;
        sum_q[slice_idx_q[SL_AW-1:0]] <= sum_new;
        recv_cnt_q                    <= recv_cnt_q + 1'b1;
        if (cnt_idx_q == LAST_CNT) begin
          cnt_idx_q   <= '0;
          slice_idx_q <= slice_idx_q + 1'b1;
        end else begin
          cnt_idx_q   <= cnt_idx_q + 1'b1;
        end
      end
      if (overrun_hit) overrun_q <= 1'b1;
      rd_data_q   <= (Rd_Addr < TOTAL_W) ? buf_q[Rd_Addr[BUF_AW-1:0]] : '0;
      slice_sum_q <= (Slice_Sel < NSLICE_W) ? sum_q[Slice_Sel[SL_AW-1:0]] : '0;
    end
  end

`ifdef RECV_RANGE_CHECK_EN
  logic range_err_q;

  always_ff @(posedge Clk) begin
    if (restart)                                 range_err_q <= 1'b0;
    else if (capture && (Counter > 32'(VAL_MAX))) range_err_q <= 1'b1;
  end

  assign Range_Err = range_err_q;
`else
  assign Range_Err = 1'b0;
`endif

  assign Rd_Data   = rd_data_q;
  assign Slice_Sum = slice_sum_q;
  assign Recv_Cnt  = recv_cnt_q;
  assign Done      = (state_q == DONE);
  assign Overrun   = overrun_q;

endmodule
